// File: rtl/uart_tx_fifo_if.sv
// Interface bundle for uart_tx_fifo: host write side, status flags and the
// start_tx / tx_start_ack / tx_done handshake towards the UART core.
//   slave  : seen by the FIFO (host/core inputs in, status and request out)
//   master : seen by whatever drives the FIFO (host plus core model)
// Ports (via signals):
//   wr_en_i, wr_data_i, flush_i  host write strobe, data, flush pulse
//   full_o, empty_o, count_o     occupancy flags and entry count
//   overflow_o, busy_o           dropped-write pulse, FSM not idle
//   tx_data_o, start_tx_o        request to core
//   tx_start_ack_i, tx_done_i    core acknowledge and frame completion
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              flush_i;
  logic              full_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              busy_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              start_tx_o;
  logic              tx_start_ack_i;
  logic              tx_done_i;

  modport slave (
    input  wr_en_i, wr_data_i, flush_i, tx_start_ack_i, tx_done_i,
    output full_o, empty_o, count_o, overflow_o, busy_o, tx_data_o, start_tx_o
  );

  modport master (
    output wr_en_i, wr_data_i, flush_i, tx_start_ack_i, tx_done_i,
    input  full_o, empty_o, count_o, overflow_o, busy_o, tx_data_o, start_tx_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit buffer between the host register block and the UART core.
// Host writes are queued in a DEPTH-entry circular buffer and launched one at
// a time to the core through the start_tx / tx_start_ack / tx_done handshake.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      uart_tx_fifo_if.slave: host write side, status, core handshake
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StReq      = 2'd1;
  localparam logic [1:0] StWaitDone = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              overflow_q, overflow_d;
  logic              busy_q;
  logic              start_q, start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [1:0]        state_q, state_d;
  logic              push, pop;

  always_comb begin
    // Full/empty are the registered flags, so a pop in the same cycle never
    // frees a slot for a write that arrives while full.
    push       = bus.wr_en_i && !full_q && !bus.flush_i;
    pop        = (state_q == StReq) && bus.tx_start_ack_i;
    overflow_d = bus.wr_en_i && full_q && !bus.flush_i;

    state_d   = state_q;
    start_d   = start_q;
    tx_data_d = tx_data_q;
    case (state_q)
      StIdle: begin
        if (!empty_q && !bus.flush_i) begin
          tx_data_d = mem_q[rd_ptr_q];
          start_d   = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        // An ack wins over a same-cycle flush: the core already took the frame.
        if (bus.tx_start_ack_i) begin
          start_d = 1'b0;
          state_d = bus.tx_done_i ? StIdle : StWaitDone;
        end else if (bus.flush_i) begin
          start_d = 1'b0;
          state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (bus.tx_done_i) state_d = StIdle;
      end
      default: begin
        start_d = 1'b0;
        state_d = StIdle;
      end
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      tx_data_q  <= '0;
      state_q    <= StIdle;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_W'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      busy_q     <= (state_d != StIdle);
      start_q    <= start_d;
      tx_data_q  <= tx_data_d;
      state_q    <= state_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data_i;
  end

  assign bus.full_o     = full_q;
  assign bus.empty_o    = empty_q;
  assign bus.count_o    = count_q;
  assign bus.overflow_o = overflow_q;
  assign bus.busy_o     = busy_q;
  assign bus.start_tx_o = start_q;
  assign bus.tx_data_o  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int maxc  = 0;
  logic [31:0] sent [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic        s_valid, s_wr, s_fl, s_ack, s_done;
  logic [31:0] s_wd;
  always @(posedge clk) begin
    s_valid <= rst_n;
    s_wr    <= bus.wr_en_i;
    s_wd    <= bus.wr_data_i;
    s_fl    <= bus.flush_i;
    s_ack   <= bus.tx_start_ack_i;
    s_done  <= bus.tx_done_i;
  end

  // Reference model: queue of pending entries plus the request phase.
  logic [31:0] mq [$];
  int          m_phase;  // 0 idle, 1 request raised, 2 frame in flight
  bit          m_start, m_ovf, m_full;
  logic [31:0] m_data;

  initial begin
    m_phase = 0; m_start = 0; m_ovf = 0; m_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_phase = 0; m_start = 0; m_ovf = 0; m_data = '0;
      end else begin
        if (s_valid) begin
          m_full = (mq.size() == DEPTH);
          m_ovf  = s_wr && m_full && !s_fl;
          if (m_phase == 0) begin
            if (mq.size() != 0 && !s_fl) begin
              m_data = mq[0]; m_start = 1; m_phase = 1;
            end
          end else if (m_phase == 1) begin
            if (s_ack) begin
              m_start = 0;
              m_phase = s_done ? 0 : 2;
              if (mq.size() > 0) void'(mq.pop_front());
            end else if (s_fl) begin
              m_start = 0; m_phase = 0;
            end
          end else if (s_done) begin
            m_phase = 0;
          end
          if (s_wr && !m_full && !s_fl) mq.push_back(s_wd);
          if (s_fl) mq.delete();
        end
        check("m_count", 32'(bus.count_o), 32'(mq.size()));
        check("m_empty", 32'(bus.empty_o), 32'(mq.size() == 0));
        check("m_full", 32'(bus.full_o), 32'(mq.size() == DEPTH));
        check("m_overflow", 32'(bus.overflow_o), 32'(m_ovf));
        check("m_start", 32'(bus.start_tx_o), 32'(m_start));
        check("m_busy", 32'(bus.busy_o), 32'(m_phase != 0));
        if (m_start) check("m_tx_data", bus.tx_data_o, m_data);
      end
    end
  end

  task automatic tick(input logic we, input logic [31:0] wd, input logic fl,
                      input logic ack, input logic done);
    bus.wr_en_i        = we;
    bus.wr_data_i      = wd;
    bus.flush_i        = fl;
    bus.tx_start_ack_i = ack;
    bus.tx_done_i      = done;
    @(negedge clk);
  endtask

  // Core model acking every request, done 'lat' cycles after ack; optional
  // host writes of base+k on two of every five cycles while not full.
  task automatic run(input int n_wr, input logic [31:0] base, input int n_sent, input int lat);
    int   wrote = 0;
    int   cyc = 0;
    int   t = 0;
    bit   inflight = 0;
    logic a, d, we;
    sent.delete();
    while (!(wrote >= n_wr && sent.size() >= n_sent && !inflight)) begin
      if (cyc > 3000) begin
        total++; bad++;
        $display("FAIL run_timeout: sent %0d of %0d, wrote %0d of %0d", sent.size(), n_sent,
                 wrote, n_wr);
        return;
      end
      a = 0; d = 0;
      if (inflight) begin
        if (t == 0) begin d = 1; inflight = 0; end
        else t--;
      end else if (bus.start_tx_o) begin
        a = 1;
        sent.push_back(bus.tx_data_o);
        if (lat == 0) d = 1;
        else begin inflight = 1; t = lat - 1; end
      end
      we = (wrote < n_wr) && (cyc % 5 < 2) && !bus.full_o;
      tick(we, base + 32'(wrote), 1'b0, a, d);
      if (we) wrote++;
      if (int'(bus.count_o) > maxc) maxc = int'(bus.count_o);
      cyc++;
    end
  endtask

  function automatic logic [31:0] sent_at(input int i);
    return (i < sent.size()) ? sent[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.wr_en_i = 0; bus.wr_data_i = '0; bus.flush_i = 0;
    bus.tx_start_ack_i = 0; bus.tx_done_i = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_count", 32'(bus.count_o), 0);
    check("rst_empty", 32'(bus.empty_o), 1);
    check("rst_full", 32'(bus.full_o), 0);
    check("rst_start", 32'(bus.start_tx_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);

    // Single byte
    tick(1, 32'h5A, 0, 0, 0);
    check("single_cnt1", 32'(bus.count_o), 1);
    check("single_nostart", 32'(bus.start_tx_o), 0);
    tick(0, 0, 0, 0, 0);
    check("single_start", 32'(bus.start_tx_o), 1);
    check("single_data", bus.tx_data_o, 32'h5A);
    tick(0, 0, 0, 1, 0);
    check("single_ack_start", 32'(bus.start_tx_o), 0);
    check("single_ack_cnt", 32'(bus.count_o), 0);
    check("single_ack_busy", 32'(bus.busy_o), 1);
    tick(0, 0, 0, 0, 1);
    check("single_done_busy", 32'(bus.busy_o), 0);
    tick(0, 0, 0, 0, 0);

    // Reset mid-request
    tick(1, 32'h77, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("rreq_start", 32'(bus.start_tx_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rreq_start0", 32'(bus.start_tx_o), 0);
    check("rreq_count0", 32'(bus.count_o), 0);
    check("rreq_empty1", 32'(bus.empty_o), 1);
    check("rreq_data0", bus.tx_data_o, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tick(0, 0, 0, 0, 0);
    check("rreq_idle", 32'(bus.start_tx_o), 0);

    // Burst to full, then overflow
    for (int i = 1; i <= 16; i++) tick(1, 32'(i), 0, 0, 0);
    check("burst_full", 32'(bus.full_o), 1);
    check("burst_count", 32'(bus.count_o), 16);
    tick(1, 32'h11, 0, 0, 0);
    check("burst_ovf", 32'(bus.overflow_o), 1);
    check("burst_count_ovf", 32'(bus.count_o), 16);
    tick(0, 0, 0, 0, 0);
    check("burst_ovf_pulse", 32'(bus.overflow_o), 0);
    run(0, 0, 16, 2);
    check("burst_nsent", 32'(sent.size()), 16);
    for (int i = 0; i < 16; i++) check("burst_data", sent_at(i), 32'(i + 1));
    check("burst_empty", 32'(bus.empty_o), 1);
    check("burst_busy", 32'(bus.busy_o), 0);

    // Wrap: 40 writes interleaved with draining
    maxc = 0;
    run(40, 32'h100, 40, 1);
    check("wrap_nsent", 32'(sent.size()), 40);
    for (int i = 0; i < 40; i++) check("wrap_data", sent_at(i), 32'h100 + 32'(i));
    check("wrap_max_le16", 32'(maxc <= 16), 1);

    // Simultaneous write and pop with count 3
    tick(1, 32'hA1, 0, 0, 0);
    tick(1, 32'hA2, 0, 0, 0);
    tick(1, 32'hA3, 0, 0, 0);
    check("sim3_count", 32'(bus.count_o), 3);
    check("sim3_start", 32'(bus.start_tx_o), 1);
    tick(1, 32'hA4, 0, 1, 0);
    check("sim3_count_kept", 32'(bus.count_o), 3);
    tick(0, 0, 0, 0, 1);
    run(0, 0, 3, 1);
    check("sim3_d0", sent_at(0), 32'hA2);
    check("sim3_d2", sent_at(2), 32'hA4);

    // Simultaneous write and pop while full: write dropped
    for (int i = 0; i < 16; i++) tick(1, 32'hB00 + 32'(i), 0, 0, 0);
    check("simf_full", 32'(bus.full_o), 1);
    tick(1, 32'hDEAD, 0, 1, 0);
    check("simf_count15", 32'(bus.count_o), 15);
    check("simf_ovf", 32'(bus.overflow_o), 1);
    tick(0, 0, 0, 0, 1);
    check("simf_ovf_pulse", 32'(bus.overflow_o), 0);
    run(0, 0, 15, 1);
    check("simf_nsent", 32'(sent.size()), 15);
    check("simf_first", sent_at(0), 32'hB01);
    check("simf_last", sent_at(14), 32'hB0F);

    // Flush during request
    for (int i = 0; i < 5; i++) tick(1, 32'hC0 + 32'(i), 0, 0, 0);
    check("flreq_start", 32'(bus.start_tx_o), 1);
    tick(0, 0, 1, 0, 0);
    check("flreq_start0", 32'(bus.start_tx_o), 0);
    check("flreq_count0", 32'(bus.count_o), 0);
    check("flreq_busy0", 32'(bus.busy_o), 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("flreq_nostart", 32'(bus.start_tx_o), 0);

    // Flush during frame in flight
    for (int i = 0; i < 5; i++) tick(1, 32'hD0 + 32'(i), 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    check("flwd_count4", 32'(bus.count_o), 4);
    tick(0, 0, 1, 0, 0);
    check("flwd_count0", 32'(bus.count_o), 0);
    check("flwd_busy", 32'(bus.busy_o), 1);
    tick(0, 0, 0, 0, 0);
    check("flwd_still_busy", 32'(bus.busy_o), 1);
    tick(0, 0, 0, 0, 1);
    check("flwd_idle", 32'(bus.busy_o), 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("flwd_empty", 32'(bus.empty_o), 1);
    check("flwd_nostart", 32'(bus.start_tx_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
